commit_unit: RTL
================

Name: commit_unit

Overview:
- In-order retirement stage directly downstream of the reorder buffer.
- Consumes the ROB head (commit_en, arch reg, value, store flag, store address).
- Non-stores retire as an architectural register-file write; stores retire as a memory write with a req/ack handshake.
- Returns a one-cycle commit_ack so the ROB advances its head, and keeps retirement statistics counters.

Parameters:
- DATA_W, 32, width of values, store data and store address
- REG_W, 5, architectural register index width
- CNT_W, 32, width of the retirement statistics counters

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- commit_en  input  1  ROB head is complete and ready to retire
- commit_arch_reg  input  REG_W  destination architectural register of the head
- commit_val  input  DATA_W  result value (register write or store data)
- commit_is_store  input  1  head is a store
- commit_store_addr  input  DATA_W  store address for a store head
- flush  input  1  abandon the in-progress retirement (pipeline squash)
- commit_ack  output  1  one-cycle pulse: head retired, ROB pops head
- rf_we  output  1  register-file write enable
- rf_waddr  output  REG_W  register-file write address
- rf_wdata  output  DATA_W  register-file write data
- st_req  output  1  store request to the memory unit, held until acked
- st_addr  output  DATA_W  store address, stable while st_req=1
- st_data  output  DATA_W  store data, stable while st_req=1
- st_ack  input  1  memory has accepted the store
- busy  output  1  state != IDLE
- retired_cnt  output  CNT_W  total instructions retired
- store_cnt  output  CNT_W  total stores retired

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Registered outputs: all outputs are registered. busy is decoded from the state register.
- Reset values: state=IDLE; commit_ack, rf_we, st_req = 0; rf_waddr, rf_wdata, st_addr, st_data = 0; retired_cnt, store_cnt = 0.
- Reset mid-operation: reset has priority over everything. It aborts a pending store: st_req is 0 in the cycle after the reset edge, and no ack is issued.
- FSM states: IDLE, STORE, ACK.
- IDLE, commit_en=1, commit_is_store=0 at edge:
  - next state ACK.
  - commit_ack<=1.
  - rf_waddr<=commit_arch_reg, rf_wdata<=commit_val.
  - rf_we<=1 only if commit_arch_reg!=0; an r0 write is suppressed but still retired and acked.
  - Latency: ack and write are visible 1 cycle after sampling.
- IDLE, commit_en=1, commit_is_store=1 at edge:
  - next state STORE.
  - st_req<=1, st_addr<=commit_store_addr, st_data<=commit_val.
  - rf_we stays 0.
- IDLE, commit_en=0: hold. st_ack in IDLE is ignored.
- STORE:
  - st_req, st_addr and st_data are held stable until st_ack=1 is sampled.
  - On st_ack: st_req<=0, commit_ack<=1, next state ACK.
  - st_ack may arrive in the first cycle st_req is high, giving a minimum of 2 cycles from sample to commit_ack.
  - No timeout; wait indefinitely.
- ACK:
  - Exactly one cycle.
  - commit_ack<=0, rf_we<=0, next state IDLE.
  - retired_cnt increments by 1; store_cnt increments by 1 if the retired instruction was a store.
  - commit_en is ignored in ACK, since the ROB head is still stale.
  - Peak throughput is 1 retire per 2 cycles.
- flush=1 (lower priority than reset):
  - next state IDLE; st_req<=0, commit_ack<=0, rf_we<=0.
  - A store in STORE is abandoned; no ack, no count.
  - A retirement already in ACK completes: its counters are updated, and the ack and write pulses already launched are not retracted.
  - flush in IDLE blocks acceptance of commit_en that cycle.
- Simultaneous st_ack and flush in STORE: flush wins; the store is not counted or acked. Memory must tolerate an abandoned accepted write. This is the documented squash semantics.
- Counter overflow: counters wrap modulo 2^CNT_W with no saturation.
- Exclusivity: commit_ack is never asserted in two consecutive cycles. rf_we and st_req are never both 1.

Test Plan:
- ALU retire: reset; IDLE, drive commit_en=1, reg=7, val=0xDEADBEEF, is_store=0 -> next cycle rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF, commit_ack=1 for exactly 1 cycle; retired_cnt=1 two cycles after sampling.
- r0 suppression: commit reg=0, val=0x55 -> rf_we stays 0, commit_ack pulses once, retired_cnt increments.
- Store handshake: commit is_store=1, addr=0x100, val=0xA5A5A5A5; hold st_ack=0 for 3 cycles, then 1 -> st_req high 4 cycles with stable addr/data, commit_ack 1 cycle after st_ack, store_cnt=1, rf_we never high.
- Back-to-back: commit_en held high with 4 ALU heads -> exactly 4 commit_ack pulses, each separated by a 0 cycle, in 8 cycles; retired_cnt=4.
- Flush during store: enter STORE, assert flush with st_ack=1 same cycle -> st_req=0 next cycle, no commit_ack, store_cnt unchanged, busy=0.
- Reset mid-store: in STORE with st_req=1, pulse reset -> st_req=0, all counters 0, state IDLE next cycle; a later store completes normally.

Source files
------------

// File: rtl/commit_unit.sv
// commit_unit: in-order retirement stage sitting directly behind the reorder buffer.
//
// Non-store heads retire as an architectural register-file write. Store heads
// retire as a memory write that uses a req/ack handshake. Each retirement
// returns a one-cycle commit_ack so the ROB can pop its head. The unit also
// keeps running counts of retired instructions and retired stores.
//
// Ports:
//   clk, reset         rising-edge clock; synchronous active-high reset
//   commit_en          ROB head is complete and ready to retire
//   commit_arch_reg    destination architectural register of the head
//   commit_val         result value (register write data or store data)
//   commit_is_store    head is a store
//   commit_store_addr  store address for a store head
//   flush              abandon the in-progress retirement
//   commit_ack         one-cycle pulse: head retired
//   rf_we/waddr/wdata  register-file write port
//   st_req/addr/data   store request to memory, held until st_ack
//   st_ack             memory accepted the store
//   busy               FSM is not idle
//   retired_cnt        total instructions retired (wraps)
//   store_cnt          total stores retired (wraps)
module commit_unit #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              commit_en,
   input  logic [REG_W-1:0]  commit_arch_reg,
   input  logic [DATA_W-1:0] commit_val,
   input  logic              commit_is_store,
   input  logic [DATA_W-1:0] commit_store_addr,
   input  logic              flush,
   output logic              commit_ack,
   output logic              rf_we,
   output logic [REG_W-1:0]  rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              st_req,
   output logic [DATA_W-1:0] st_addr,
   output logic [DATA_W-1:0] st_data,
   input  logic              st_ack,
   output logic              busy,
   output logic [CNT_W-1:0]  retired_cnt,
   output logic [CNT_W-1:0]  store_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STORE = 2'd1,
      ACK   = 2'd2
   } state_t;

   state_t              state, state_nx;
   logic                ack_nx, rf_we_nx, st_req_nx;
   logic [REG_W-1:0]    rf_waddr_nx;
   logic [DATA_W-1:0]   rf_wdata_nx, st_addr_nx, st_data_nx;
   logic [CNT_W-1:0]    retired_cnt_nx, store_cnt_nx;
   // Records whether the retirement now in ACK was a store. It steers the
   // store_cnt update.
   logic                was_store, was_store_nx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         commit_ack  <= 1'b0;
         rf_we       <= 1'b0;
         rf_waddr    <= '0;
         rf_wdata    <= '0;
         st_req      <= 1'b0;
         st_addr     <= '0;
         st_data     <= '0;
         retired_cnt <= '0;
         store_cnt   <= '0;
         was_store   <= 1'b0;
      end else begin
         state       <= state_nx;
         commit_ack  <= ack_nx;
         rf_we       <= rf_we_nx;
         rf_waddr    <= rf_waddr_nx;
         rf_wdata    <= rf_wdata_nx;
         st_req      <= st_req_nx;
         st_addr     <= st_addr_nx;
         st_data     <= st_data_nx;
         retired_cnt <= retired_cnt_nx;
         store_cnt   <= store_cnt_nx;
         was_store   <= was_store_nx;
      end
   end

   always_comb begin
      state_nx       = state;
      ack_nx         = 1'b0;
      rf_we_nx       = 1'b0;
      rf_waddr_nx    = rf_waddr;
      rf_wdata_nx    = rf_wdata;
      st_req_nx      = st_req;
      st_addr_nx     = st_addr;
      st_data_nx     = st_data;
      retired_cnt_nx = retired_cnt;
      store_cnt_nx   = store_cnt;
      was_store_nx   = was_store;

      unique case (state)
         IDLE: begin
            if (commit_en && !flush) begin
               if (commit_is_store) begin
                  state_nx     = STORE;
                  st_req_nx    = 1'b1;
                  st_addr_nx   = commit_store_addr;
                  st_data_nx   = commit_val;
                  was_store_nx = 1'b1;
               end else begin
                  state_nx     = ACK;
                  ack_nx       = 1'b1;
                  rf_waddr_nx  = commit_arch_reg;
                  rf_wdata_nx  = commit_val;
                  // An r0 destination still retires and is acked. Only the
                  // register write is dropped.
                  rf_we_nx     = (commit_arch_reg != '0);
                  was_store_nx = 1'b0;
               end
            end
         end
         STORE: begin
            if (st_ack) begin
               st_req_nx = 1'b0;
               ack_nx    = 1'b1;
               state_nx  = ACK;
            end
         end
         ACK: begin
            // The ROB head is stale in this cycle, so commit_en is ignored.
            state_nx       = IDLE;
            retired_cnt_nx = retired_cnt + CNT_W'(1);
            if (was_store)
               store_cnt_nx = store_cnt + CNT_W'(1);
         end
         default: state_nx = IDLE;
      endcase

      // A squash overrides the handshake and the pulses. A retirement already
      // in ACK keeps its counter update from the case above.
      if (flush) begin
         state_nx  = IDLE;
         st_req_nx = 1'b0;
         ack_nx    = 1'b0;
         rf_we_nx  = 1'b0;
      end
   end

   assign busy = (state != IDLE);

endmodule
